midi_uart_rx: RTL and testbench

// - Parametrised UART/MIDI serial receiver: 8N1 at 31,250 baud by default, widths and timing generic.
// - Sits between the MIDI opto-isolator input pin and the MIDI message parser.
// - Adds input synchronisation, mid-bit sampling, false-start rejection and framing-error detection.
// - Buffers received bytes in a FIFO and delivers them over a valid/ready handshake.

---
 rtl/midi_pkg.sv | 22 ++
 rtl/rx_fifo.sv | 56 +++++
 rtl/midi_uart_rx.sv | 158 +++++++++++++++
 tb/tb_midi_uart_rx.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI serial receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package midi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rxState_t;

  localparam int MIDI_BAUD = 31250;
  localparam int CLK_HZ    = 50_000_000;

  // Clock cycles per serial bit, rounded to the nearest whole cycle.
  function automatic int clksPerBit(input int clkHz, input int baud);
    return (clkHz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Latency: pushed word visible at popData the cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         popData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rdPtr;
  logic [AW-1:0]    wrPtr;
  logic             doPush;
  logic             doPop;

  // Full/empty come from the count so pointer wrap never needs an extra bit.
  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign doPop   = pop & ~empty;
  assign doPush  = push & (~full | doPop);
  assign popData = empty ? '0 : mem[rdPtr];

  // Pointers and occupancy; simultaneous push and pop leave the count alone.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, popData masks them while empty.
  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/midi_uart_rx.sv
// UART/MIDI 8N1 receiver: synchroniser, mid-bit sampling, framing check, FWFT byte FIFO.
// Latency: byte pushed on the stop-bit sample edge, dataValid one cycle later.
// Backpressure: dataReady pops the FIFO head; a byte completing while full is dropped with an overflow pulse.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = clksPerBit(CLK_HZ, MIDI_BAUD),
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic                          uartStream,
  output logic [DATA_BITS-1:0]          dataOut,
  output logic                          dataValid,
  input  logic                          dataReady,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic                          frameError,
  output logic                          overflow,
  output logic                          busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL     = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] syncReg;
  logic                   rxLine;
  rxState_t               state;
  rxState_t               stateNext;
  logic [CW-1:0]          clkCnt;
  logic [BW-1:0]          bitIdx;
  logic [DATA_BITS-1:0]   shiftReg;

  logic cntClear;
  logic shiftEn;
  logic idxClear;
  logic pushByte;
  logic frameErrSet;
  logic fifoFull;
  logic fifoEmpty;

  assign rxLine    = syncReg[SYNC_STAGES-1];
  assign busy      = (state != IDLE);
  assign dataValid = ~fifoEmpty;

  // Metastability synchroniser, preset high so reset looks like an idle line.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) syncReg <= '1;
    else         syncReg <= {syncReg[SYNC_STAGES-2:0], uartStream};
  end

  // Receiver state register.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= stateNext;
  end

  // Next-state decode and per-cycle datapath controls.
  always_comb begin
    stateNext   = state;
    cntClear    = 1'b0;
    shiftEn     = 1'b0;
    idxClear    = 1'b0;
    pushByte    = 1'b0;
    frameErrSet = 1'b0;
    unique case (state)
      IDLE: begin
        cntClear = 1'b1;
        if (!rxLine) stateNext = START;
      end
      START: begin
        // Half a bit in: still low means a real start bit, high means a glitch.
        if (clkCnt == HALF) begin
          cntClear = 1'b1;
          if (rxLine) begin
            stateNext = IDLE;
          end else begin
            stateNext = DATA;
            idxClear  = 1'b1;
          end
        end
      end
      DATA: begin
        if (clkCnt == FULL) begin
          cntClear = 1'b1;
          shiftEn  = 1'b1;
          if (bitIdx == LAST_BIT) stateNext = STOP;
        end
      end
      STOP: begin
        if (clkCnt == FULL) begin
          cntClear = 1'b1;
          if (rxLine) begin
            pushByte  = 1'b1;
            stateNext = IDLE;
          end else begin
            frameErrSet = 1'b1;
            stateNext   = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low (break) line is waited out silently.
        cntClear = 1'b1;
        if (rxLine) stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Bit timer, bit index and LSB-first shift register.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      clkCnt   <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
    end else begin
      clkCnt <= cntClear ? '0 : clkCnt + CW'(1);
      if (idxClear)     bitIdx <= '0;
      else if (shiftEn) bitIdx <= bitIdx + BW'(1);
      if (shiftEn) shiftReg <= {rxLine, shiftReg[DATA_BITS-1:1]};
    end
  end

  // One-cycle status pulses; a pop in the same cycle makes room, so no overflow then.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      frameError <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frameError <= frameErrSet;
      overflow   <= pushByte & fifoFull & ~(dataReady & dataValid);
    end
  end

  rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clock    (clock),
    .resetN   (resetN),
    .push     (pushByte),
    .pushData (shiftReg),
    .pop      (dataReady),
    .popData  (dataOut),
    .count    (fifoCount),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

endmodule

// File: tb/tb_midi_uart_rx.sv
// Directed and randomized checks of midi_uart_rx against a queue-based reference model.
// Latency: n/a (testbench).
// Backpressure: dataReady driven by the stimulus, held, pulsed or randomized per test.
module tb_midi_uart_rx;

  localparam int CPB     = 16;
  localparam int DEPTH   = 4;
  localparam int CPB_DEF = 1600;
  localparam int SYNC    = 2;
  // Edges from driving the start bit to the stop-bit sample edge:
  // synchroniser, one IDLE detect cycle, half a bit, eight data bits and the stop bit.
  localparam int STOP_EDGE = SYNC + 1 + CPB / 2 + 9 * CPB;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       resetN;
  logic       uartStream;
  logic       dataReady;
  logic [7:0] dataOut;
  logic       dataValid;
  logic [2:0] fifoCount;
  logic       frameError;
  logic       overflow;
  logic       busy;

  logic       streamDef;
  logic       readyDef;
  logic [7:0] dataOutDef;
  logic       dataValidDef;
  logic [4:0] fifoCountDef;
  logic       frameErrorDef;
  logic       overflowDef;
  logic       busyDef;

  midi_uart_rx #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8),
    .FIFO_DEPTH   (DEPTH),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clock      (clock),
    .resetN     (resetN),
    .uartStream (uartStream),
    .dataOut    (dataOut),
    .dataValid  (dataValid),
    .dataReady  (dataReady),
    .fifoCount  (fifoCount),
    .frameError (frameError),
    .overflow   (overflow),
    .busy       (busy)
  );

  midi_uart_rx dutDef (
    .clock      (clock),
    .resetN     (resetN),
    .uartStream (streamDef),
    .dataOut    (dataOutDef),
    .dataValid  (dataValidDef),
    .dataReady  (readyDef),
    .fifoCount  (fifoCountDef),
    .frameError (frameErrorDef),
    .overflow   (overflowDef),
    .busy       (busyDef)
  );

  int total = 0;
  int bad   = 0;

  int validCycles = 0;
  int feCnt       = 0;
  int ovCnt       = 0;
  int bothTotal   = 0;
  int feDef       = 0;
  int ovDef       = 0;
  logic [7:0] popped[$];
  logic [7:0] expQ[$];
  logic [7:0] rq[$];
  logic [7:0] rb;
  logic [7:0] aa;
  bit         done;

  // Observe the DUT away from the active edge: pops, valid cycles and flag pulses.
  always @(negedge clock) begin
    if (resetN) begin
      if (dataValid) validCycles++;
      if (dataValid && dataReady) popped.push_back(dataOut);
      if (frameError) feCnt++;
      if (overflow) ovCnt++;
      if (frameError && overflow) bothTotal++;
      if (frameErrorDef) feDef++;
      if (overflowDef) ovDef++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearMon();
    popped.delete();
    expQ.delete();
    validCycles = 0;
    feCnt       = 0;
    ovCnt       = 0;
  endtask

  task automatic setLine(input bit useDef, input logic v);
    if (useDef) streamDef = v;
    else        uartStream = v;
  endtask

  // One 8N1 frame, LSB first; the line is left at the stop-bit level afterwards.
  task automatic sendFrame(input logic [7:0] b, input logic stopBit, input bit useDef);
    int cpb;
    cpb = useDef ? CPB_DEF : CPB;
    setLine(useDef, 1'b0);
    tick(cpb);
    for (int i = 0; i < 8; i++) begin
      setLine(useDef, b[i]);
      tick(cpb);
    end
    setLine(useDef, stopBit);
    tick(cpb);
  endtask

  task automatic checkQueue(input string tag);
    logic [7:0] o;
    chk({tag, "_count"}, popped.size(), expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      o = (i < popped.size()) ? popped[i] : 8'hxx;
      chk({tag, "_byte"}, o, expQ[i]);
    end
  endtask

  initial begin
    resetN     = 1'b0;
    uartStream = 1'b1;
    dataReady  = 1'b0;
    streamDef  = 1'b1;
    readyDef   = 1'b0;
    done       = 1'b0;
    aa         = 8'hAA;
    tick(3);

    // Reset state.
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", dataValid, 1'b0);
    chk("rst_count", fifoCount, 3'd0);
    chk("rst_dout", dataOut, 8'h00);
    chk("rst_ferr", frameError, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    resetN = 1'b1;
    tick(3);

    // Single byte with the consumer always ready.
    clearMon();
    dataReady = 1'b1;
    sendFrame(8'h90, 1'b1, 1'b0);
    tick(4);
    expQ = {8'h90};
    checkQueue("t1");
    chk("t1_valid_cycles", validCycles, 1);
    chk("t1_ferr", feCnt, 0);
    chk("t1_ovf", ovCnt, 0);

    // Five-clock low glitch on an idle line.
    clearMon();
    uartStream = 1'b0;
    tick(4);
    chk("glitch_busy_hi", busy, 1'b1);
    tick(1);
    uartStream = 1'b1;
    tick(7);
    chk("glitch_busy_lo", busy, 1'b0);
    chk("glitch_count", fifoCount, 3'd0);
    chk("glitch_ferr", feCnt, 0);
    chk("glitch_pops", popped.size(), 0);

    // Framing error followed by a long break, then a good frame.
    clearMon();
    sendFrame(8'h3C, 1'b0, 1'b0);
    tick(40 * CPB);
    chk("ferr_busy_break", busy, 1'b1);
    chk("ferr_pulses", feCnt, 1);
    chk("ferr_count", fifoCount, 3'd0);
    chk("ferr_pops", popped.size(), 0);
    uartStream = 1'b1;
    tick(4);
    chk("ferr_busy_idle", busy, 1'b0);
    sendFrame(8'h45, 1'b1, 1'b0);
    tick(4);
    expQ = {8'h45};
    checkQueue("ferr_next");
    chk("ferr_pulses_after", feCnt, 1);

    // Fill and overflow with the consumer stalled, then drain.
    clearMon();
    dataReady = 1'b0;
    for (int b = 1; b <= 4; b++) sendFrame(8'(b), 1'b1, 1'b0);
    chk("ovf_count4", fifoCount, 3'd4);
    chk("ovf_none_yet", ovCnt, 0);
    sendFrame(8'h05, 1'b1, 1'b0);
    tick(2);
    chk("ovf_pulse", ovCnt, 1);
    chk("ovf_count_hold", fifoCount, 3'd4);
    chk("ovf_head", dataOut, 8'h01);
    chk("ovf_valid", dataValid, 1'b1);
    dataReady = 1'b1;
    tick(8);
    dataReady = 1'b0;
    expQ = {8'h01, 8'h02, 8'h03, 8'h04};
    checkQueue("ovf_drain");
    chk("ovf_drained", fifoCount, 3'd0);

    // Full FIFO with a pop exactly on the stop-sample edge of the next byte.
    clearMon();
    rq.delete();
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom_range(0, 255));
      rq.push_back(rb);
      sendFrame(rb, 1'b1, 1'b0);
    end
    chk("fullpop_count_pre", fifoCount, 3'd4);
    fork
      sendFrame(8'h7F, 1'b1, 1'b0);
      begin
        tick(STOP_EDGE - 1);
        dataReady = 1'b1;
        tick(1);
        dataReady = 1'b0;
      end
    join
    tick(2);
    chk("fullpop_ovf", ovCnt, 0);
    chk("fullpop_count", fifoCount, 3'd4);
    expQ = {rq[0]};
    checkQueue("fullpop_first");
    clearMon();
    dataReady = 1'b1;
    tick(8);
    dataReady = 1'b0;
    expQ = {rq[1], rq[2], rq[3], 8'h7F};
    checkQueue("fullpop_drain");

    // Reset asserted during bit 3 of a frame while the FIFO holds a byte.
    clearMon();
    sendFrame(8'h33, 1'b1, 1'b0);
    chk("mrst_count_pre", fifoCount, 3'd1);
    uartStream = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      uartStream = aa[i];
      tick(CPB);
    end
    uartStream = aa[3];
    tick(CPB / 2);
    chk("mrst_busy_pre", busy, 1'b1);
    resetN = 1'b0;
    #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_valid", dataValid, 1'b0);
    chk("mrst_count", fifoCount, 3'd0);
    chk("mrst_dout", dataOut, 8'h00);
    chk("mrst_ferr", frameError, 1'b0);
    chk("mrst_ovf", overflow, 1'b0);
    tick(1);
    resetN     = 1'b1;
    uartStream = 1'b1;
    tick(3 * CPB);
    chk("mrst_idle", busy, 1'b0);
    chk("mrst_flags", feCnt + ovCnt, 0);
    dataReady = 1'b1;
    sendFrame(8'h55, 1'b1, 1'b0);
    tick(4);
    expQ = {8'h55};
    checkQueue("mrst_next");

    // Random bytes, random gaps (including back-to-back), random consumer readiness.
    clearMon();
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          rb = 8'($urandom_range(0, 255));
          expQ.push_back(rb);
          tick(int'($urandom_range(0, 20)));
          sendFrame(rb, 1'b1, 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          dataReady = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    dataReady = 1'b1;
    tick(20);
    checkQueue("rand");
    chk("rand_ovf", ovCnt, 0);
    chk("rand_ferr", feCnt, 0);
    chk("flags_exclusive", bothTotal, 0);

    // Default parameters: 1600 clocks per bit, 16-deep FIFO.
    readyDef = 1'b0;
    sendFrame(8'h90, 1'b1, 1'b1);
    tick(4);
    chk("def_valid", dataValidDef, 1'b1);
    chk("def_dout", dataOutDef, 8'h90);
    chk("def_count", fifoCountDef, 5'd1);
    chk("def_busy", busyDef, 1'b0);
    chk("def_flags", feDef + ovDef, 0);
    readyDef = 1'b1;
    tick(2);
    chk("def_popped", dataValidDef, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
